mc_control_unit: RTL and testbench

//  Multi-cycle control FSM for the 16-bit TSC CPU. It sits directly upstream of the

---
 rtl/mc_control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// mc_control_unit
//   Multi-cycle control FSM for the 16-bit TSC CPU. Decodes the datapath's
//   instruction register at every step, drives the datapath control word,
//   counts retired instructions and reports halt state.
//
// Ports
//   clk          in   clock, all state changes on posedge
//   reset_n      in   asynchronous active-low reset
//   instruction  in   current IR (opcode [15:12], func [5:0])
//   signal       out  control word:
//                     [15:14] PCSource  [13] ALUOp     [12:11] ALUSrcB
//                     [10] ALUSrcA      [9] RegWrite   [8:7] RegDst
//                     [6] PCWriteCond   [5] PCWrite    [4] IorD
//                     [3] MemRead       [2] MemWrite   [1] MemtoReg
//                     [0] IRWrite
//   state        out  current FSM state (IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5)
//   num_inst     out  retired-instruction count, wraps
//   is_halted    out  high while in HALT
module mc_control_unit #(
    parameter int unsigned WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] instruction,
    output logic [15:0]          signal,
    output logic [2:0]           state,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic                 is_halted
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // Opcodes
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_R   = 4'd15;

    // R-type function codes
    localparam logic [5:0] FN_ALU_MAX = 6'd7;
    localparam logic [5:0] FN_JPR     = 6'd25;
    localparam logic [5:0] FN_JRL     = 6'd26;
    localparam logic [5:0] FN_WWD     = 6'd28;
    localparam logic [5:0] FN_HLT     = 6'd29;

    // Control words
    localparam logic [15:0] SIG_IF       = 16'h0009;
    localparam logic [15:0] SIG_ID       = 16'h0820;
    localparam logic [15:0] SIG_ID_JUMP  = 16'h8020;
    localparam logic [15:0] SIG_EX_RALU  = 16'h2400;
    localparam logic [15:0] SIG_EX_ADI   = 16'h3400;
    localparam logic [15:0] SIG_EX_LOGIC = 16'h3C00;
    localparam logic [15:0] SIG_EX_MEM   = 16'h1400;
    localparam logic [15:0] SIG_EX_BR    = 16'h0440;
    localparam logic [15:0] SIG_EX_JREG  = 16'h0600;
    localparam logic [15:0] SIG_MEM_LWD  = 16'h0018;
    localparam logic [15:0] SIG_MEM_SWD  = 16'h0014;
    localparam logic [15:0] SIG_WB_RALU  = 16'h0280;
    localparam logic [15:0] SIG_WB_IMM   = 16'h0200;
    localparam logic [15:0] SIG_WB_LWD   = 16'h0202;
    localparam logic [15:0] SIG_WB_LINK  = 16'h0300;

    localparam logic [WORD_SIZE-1:0] COUNT_ONE = 1;

    state_t stateReg;
    state_t nextState;
    logic [WORD_SIZE-1:0] numInst;

    logic [3:0] opcode;
    logic [5:0] func;
    logic       unusedFields;

    logic isRType, isRAlu, isJpr, isJrl, isWwd, isHlt;
    logic isBranch, isAdi, isOri, isLhi, isLwd, isSwd, isJmp, isJal;
    logic isImm, isDefined;
    logic countUp;

    assign opcode       = instruction[WORD_SIZE-1:WORD_SIZE-4];
    assign func         = instruction[5:0];
    assign unusedFields = ^instruction[WORD_SIZE-5:6];

    // Instruction decode
    always_comb begin
        isRType   = (opcode == OP_R);
        isRAlu    = isRType && (func <= FN_ALU_MAX);
        isJpr     = isRType && (func == FN_JPR);
        isJrl     = isRType && (func == FN_JRL);
        isWwd     = isRType && (func == FN_WWD);
        isHlt     = isRType && (func == FN_HLT);
        isBranch  = (opcode <= 4'd3);
        isAdi     = (opcode == OP_ADI);
        isOri     = (opcode == OP_ORI);
        isLhi     = (opcode == OP_LHI);
        isLwd     = (opcode == OP_LWD);
        isSwd     = (opcode == OP_SWD);
        isJmp     = (opcode == OP_JMP);
        isJal     = (opcode == OP_JAL);
        isImm     = isAdi || isOri || isLhi;
        isDefined = isRAlu || isJpr || isJrl || isWwd || isHlt || isBranch ||
                    isImm || isLwd || isSwd || isJmp || isJal;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= S_IF;
        end else begin
            stateReg <= nextState;
        end
    end

    // Next state and Moore control word
    always_comb begin
        nextState = S_IF;
        signal    = '0;
        unique case (stateReg)
            S_IF: begin
                signal    = SIG_IF;
                nextState = S_ID;
            end
            S_ID: begin
                signal = (isJmp || isJal) ? SIG_ID_JUMP : SIG_ID;
                if (!isDefined || isJmp) begin
                    nextState = S_IF;
                end else if (isJal) begin
                    nextState = S_WB;
                end else if (isHlt) begin
                    nextState = S_HALT;
                end else begin
                    nextState = S_EX;
                end
            end
            S_EX: begin
                if (isRAlu || isWwd) begin
                    signal = SIG_EX_RALU;
                end else if (isAdi) begin
                    signal = SIG_EX_ADI;
                end else if (isOri || isLhi) begin
                    signal = SIG_EX_LOGIC;
                end else if (isLwd || isSwd) begin
                    signal = SIG_EX_MEM;
                end else if (isBranch) begin
                    signal = SIG_EX_BR;
                end else if (isJpr || isJrl) begin
                    signal = SIG_EX_JREG;
                end
                if (isLwd || isSwd) begin
                    nextState = S_MEM;
                end else if (isRAlu || isImm || isJrl) begin
                    nextState = S_WB;
                end else begin
                    nextState = S_IF;
                end
            end
            S_MEM: begin
                if (isLwd) begin
                    signal    = SIG_MEM_LWD;
                    nextState = S_WB;
                end else if (isSwd) begin
                    signal    = SIG_MEM_SWD;
                end
            end
            S_WB: begin
                if (isRAlu) begin
                    signal = SIG_WB_RALU;
                end else if (isImm) begin
                    signal = SIG_WB_IMM;
                end else if (isLwd) begin
                    signal = SIG_WB_LWD;
                end else if (isJal || isJrl) begin
                    signal = SIG_WB_LINK;
                end
            end
            S_HALT: begin
                nextState = S_HALT;
            end
            default: begin
                nextState = S_IF;
            end
        endcase
    end

    // An instruction retires on the edge that returns to IF; HLT retires on
    // entry to HALT and the count then freezes.
    assign countUp = ((nextState == S_IF)   && (stateReg != S_IF)) ||
                     ((nextState == S_HALT) && (stateReg != S_HALT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            numInst <= '0;
        end else if (countUp) begin
            numInst <= numInst + COUNT_ONE;
        end
    end

    assign state     = stateReg;
    assign num_inst  = numInst;
    assign is_halted = (stateReg == S_HALT);

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

    logic        clk;
    logic        reset_n;
    logic [15:0] instruction;
    logic [15:0] signal;
    logic [2:0]  state;
    logic [15:0] num_inst;
    logic        is_halted;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] expCount;

    mc_control_unit #(.WORD_SIZE(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .instruction(instruction),
        .signal     (signal),
        .state      (state),
        .num_inst   (num_inst),
        .is_halted  (is_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        instruction = 16'hF1C0;
        repeat (3) step();
        checks++; if (signal !== 16'h0009) begin errors++; $display("FAIL reset_signal got %h exp 0009", signal); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (num_inst !== 16'h0000) begin errors++; $display("FAIL reset_num_inst got %h exp 0000", num_inst); end
        checks++; if (is_halted !== 1'b0) begin errors++; $display("FAIL reset_is_halted got %b exp 0", is_halted); end
        reset_n  = 1'b1;
        expCount = 16'h0000;
    endtask

    task automatic test_add();
        logic [15:0] sig [4] = '{16'h0009, 16'h0820, 16'h2400, 16'h0280};
        logic [2:0]  st  [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        instruction = 16'hF1C0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (signal !== sig[i]) begin errors++; $display("FAIL add_signal[%0d] got %h exp %h", i, signal, sig[i]); end
            checks++; if (state !== st[i]) begin errors++; $display("FAIL add_state[%0d] got %0d exp %0d", i, state, st[i]); end
            checks++; if (num_inst !== expCount) begin errors++; $display("FAIL add_num_inst[%0d] got %h exp %h", i, num_inst, expCount); end
            step();
        end
        expCount++;
        checks++; if (state !== 3'd0 || num_inst !== expCount) begin errors++; $display("FAIL add_retire state %0d num_inst %h exp 0/%h", state, num_inst, expCount); end
    endtask

    task automatic test_lwd();
        logic [15:0] sig [5] = '{16'h0009, 16'h0820, 16'h1400, 16'h0018, 16'h0202};
        logic [2:0]  st  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        instruction = 16'h7401;
        for (int i = 0; i < 5; i++) begin
            checks++; if (signal !== sig[i] || state !== st[i]) begin errors++; $display("FAIL lwd_step[%0d] got %h/%0d exp %h/%0d", i, signal, state, sig[i], st[i]); end
            step();
        end
        expCount++;
        checks++; if (state !== 3'd0 || num_inst !== expCount) begin errors++; $display("FAIL lwd_retire state %0d num_inst %h exp 0/%h", state, num_inst, expCount); end
    endtask

    task automatic test_swd();
        logic [15:0] sig [4] = '{16'h0009, 16'h0820, 16'h1400, 16'h0014};
        logic [2:0]  st  [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        instruction = 16'h8401;
        for (int i = 0; i < 4; i++) begin
            checks++; if (signal !== sig[i] || state !== st[i]) begin errors++; $display("FAIL swd_step[%0d] got %h/%0d exp %h/%0d", i, signal, state, sig[i], st[i]); end
            step();
        end
        expCount++;
        checks++; if (state !== 3'd0 || num_inst !== expCount) begin errors++; $display("FAIL swd_retire state %0d num_inst %h exp 0/%h", state, num_inst, expCount); end
    endtask

    task automatic test_branch();
        logic [15:0] sig [3] = '{16'h0009, 16'h0820, 16'h0440};
        logic [2:0]  st  [3] = '{3'd0, 3'd1, 3'd2};
        instruction = 16'h1123;
        for (int i = 0; i < 3; i++) begin
            checks++; if (signal !== sig[i] || state !== st[i]) begin errors++; $display("FAIL branch_step[%0d] got %h/%0d exp %h/%0d", i, signal, state, sig[i], st[i]); end
            step();
        end
        expCount++;
        checks++; if (state !== 3'd0 || num_inst !== expCount) begin errors++; $display("FAIL branch_retire state %0d num_inst %h exp 0/%h", state, num_inst, expCount); end
    endtask

    task automatic test_adi();
        logic [15:0] sig [4] = '{16'h0009, 16'h0820, 16'h3400, 16'h0200};
        logic [2:0]  st  [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        instruction = 16'h4105;
        for (int i = 0; i < 4; i++) begin
            checks++; if (signal !== sig[i] || state !== st[i]) begin errors++; $display("FAIL adi_step[%0d] got %h/%0d exp %h/%0d", i, signal, state, sig[i], st[i]); end
            step();
        end
        expCount++;
        checks++; if (state !== 3'd0 || num_inst !== expCount) begin errors++; $display("FAIL adi_retire state %0d num_inst %h exp 0/%h", state, num_inst, expCount); end
    endtask

    task automatic test_jal();
        logic [15:0] sig [3] = '{16'h0009, 16'h8020, 16'h0300};
        logic [2:0]  st  [3] = '{3'd0, 3'd1, 3'd4};
        instruction = 16'hA005;
        for (int i = 0; i < 3; i++) begin
            checks++; if (signal !== sig[i] || state !== st[i]) begin errors++; $display("FAIL jal_step[%0d] got %h/%0d exp %h/%0d", i, signal, state, sig[i], st[i]); end
            step();
        end
        expCount++;
        checks++; if (state !== 3'd0 || num_inst !== expCount) begin errors++; $display("FAIL jal_retire state %0d num_inst %h exp 0/%h", state, num_inst, expCount); end
    endtask

    task automatic test_jrl();
        logic [15:0] sig [4] = '{16'h0009, 16'h0820, 16'h0600, 16'h0300};
        logic [2:0]  st  [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        instruction = 16'hF01A;
        for (int i = 0; i < 4; i++) begin
            checks++; if (signal !== sig[i] || state !== st[i]) begin errors++; $display("FAIL jrl_step[%0d] got %h/%0d exp %h/%0d", i, signal, state, sig[i], st[i]); end
            step();
        end
        expCount++;
        checks++; if (state !== 3'd0 || num_inst !== expCount) begin errors++; $display("FAIL jrl_retire state %0d num_inst %h exp 0/%h", state, num_inst, expCount); end
    endtask

    task automatic test_wwd();
        logic [15:0] sig [3] = '{16'h0009, 16'h0820, 16'h2400};
        logic [2:0]  st  [3] = '{3'd0, 3'd1, 3'd2};
        instruction = 16'hF01C;
        for (int i = 0; i < 3; i++) begin
            checks++; if (signal !== sig[i] || state !== st[i]) begin errors++; $display("FAIL wwd_step[%0d] got %h/%0d exp %h/%0d", i, signal, state, sig[i], st[i]); end
            step();
        end
        expCount++;
        checks++; if (state !== 3'd0 || num_inst !== expCount) begin errors++; $display("FAIL wwd_retire state %0d num_inst %h exp 0/%h", state, num_inst, expCount); end
    endtask

    task automatic test_undefined();
        logic [15:0] ops [2] = '{16'hB000, 16'hF010};
        for (int k = 0; k < 2; k++) begin
            instruction = ops[k];
            checks++; if (signal !== 16'h0009 || state !== 3'd0) begin errors++; $display("FAIL undef_if[%0d] got %h/%0d exp 0009/0", k, signal, state); end
            step();
            checks++; if (signal !== 16'h0820 || state !== 3'd1) begin errors++; $display("FAIL undef_id[%0d] got %h/%0d exp 0820/1", k, signal, state); end
            step();
            expCount++;
            checks++; if (state !== 3'd0 || num_inst !== expCount) begin errors++; $display("FAIL undef_retire[%0d] state %0d num_inst %h exp 0/%h", k, state, num_inst, expCount); end
        end
    endtask

    task automatic test_jmp();
        instruction = 16'h9005;
        for (int i = 0; i < 10; i++) begin
            checks++; if (signal !== 16'h0009 || state !== 3'd0) begin errors++; $display("FAIL jmp_if[%0d] got %h/%0d exp 0009/0", i, signal, state); end
            step();
            checks++; if (signal !== 16'h8020 || state !== 3'd1) begin errors++; $display("FAIL jmp_id[%0d] got %h/%0d exp 8020/1", i, signal, state); end
            step();
        end
        expCount = expCount + 16'd10;
        checks++; if (num_inst !== expCount) begin errors++; $display("FAIL jmp_count got %h exp %h", num_inst, expCount); end
    endtask

    task automatic test_ori_reset();
        instruction = 16'h5123;
        step();
        step();
        checks++; if (signal !== 16'h3C00 || state !== 3'd2) begin errors++; $display("FAIL ori_ex got %h/%0d exp 3C00/2", signal, state); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (signal !== 16'h0009 || state !== 3'd0) begin errors++; $display("FAIL ori_async_reset got %h/%0d exp 0009/0", signal, state); end
        checks++; if (num_inst !== 16'h0000 || is_halted !== 1'b0) begin errors++; $display("FAIL ori_reset_count got %h/%b exp 0000/0", num_inst, is_halted); end
        reset_n  = 1'b1;
        expCount = 16'h0000;
        step();
        checks++; if (signal !== 16'h0820 || state !== 3'd1) begin errors++; $display("FAIL ori_refetch_id got %h/%0d exp 0820/1", signal, state); end
        step();
        step();
        checks++; if (signal !== 16'h0200 || state !== 3'd4) begin errors++; $display("FAIL ori_wb got %h/%0d exp 0200/4", signal, state); end
        step();
        expCount++;
        checks++; if (state !== 3'd0 || num_inst !== expCount) begin errors++; $display("FAIL ori_retire state %0d num_inst %h exp 0/%h", state, num_inst, expCount); end
    endtask

    task automatic test_wrap();
        // Jump the counter close to its limit instead of retiring 65534 JMPs.
        force dut.numInst = 16'hFFFE;
        #1;
        release dut.numInst;
        #1;
        expCount = 16'hFFFE;
        checks++; if (num_inst !== expCount) begin errors++; $display("FAIL wrap_preload got %h exp %h", num_inst, expCount); end
        @(negedge clk);
        instruction = 16'h9001;
        for (int i = 0; i < 3; i++) begin
            step();
            step();
            expCount++;
            checks++; if (num_inst !== expCount || state !== 3'd0) begin errors++; $display("FAIL wrap_count[%0d] got %h/%0d exp %h/0", i, num_inst, state, expCount); end
        end
    endtask

    task automatic test_halt();
        instruction = 16'hF01D;
        checks++; if (signal !== 16'h0009 || state !== 3'd0) begin errors++; $display("FAIL halt_if got %h/%0d exp 0009/0", signal, state); end
        step();
        checks++; if (signal !== 16'h0820 || state !== 3'd1) begin errors++; $display("FAIL halt_id got %h/%0d exp 0820/1", signal, state); end
        step();
        expCount++;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (signal !== 16'h0000 || state !== 3'd5 || is_halted !== 1'b1 || num_inst !== expCount) begin
                errors++;
                $display("FAIL halt_hold[%0d] got sig %h st %0d halted %b cnt %h exp 0000/5/1/%h", i, signal, state, is_halted, num_inst, expCount);
            end
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (signal !== 16'h0009 || state !== 3'd0 || is_halted !== 1'b0 || num_inst !== 16'h0000) begin errors++; $display("FAIL halt_exit got sig %h st %0d halted %b cnt %h exp 0009/0/0/0000", signal, state, is_halted, num_inst); end
        reset_n  = 1'b1;
        expCount = 16'h0000;
    endtask

    initial begin
        reset_n     = 1'b0;
        instruction = 16'h0000;
        expCount    = 16'h0000;
        test_reset();
        test_add();
        test_lwd();
        test_swd();
        test_branch();
        test_adi();
        test_jal();
        test_jrl();
        test_wwd();
        test_undefined();
        test_jmp();
        test_ori_reset();
        test_wrap();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
